// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP              = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HOLD   = 2'd2,
        SQUASH = 2'd3
    } if_state_e;

    // Fetch addresses are always word aligned.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_buf.sv
// One-entry buffer for a response that arrives while ID is stalled.
module if_fetch_buf
    import if_stage_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] d_inst,
    input  logic [XLEN-1:0] d_pc,
    output logic [XLEN-1:0] q_inst,
    output logic [XLEN-1:0] q_pc,
    output logic            full
);

    // Clear wins over load so a redirect always empties the entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_inst <= NOP;
            q_pc   <= '0;
            full   <= 1'b0;
        end else if (clear) begin
            full   <= 1'b0;
        end else if (load) begin
            q_inst <= d_inst;
            q_pc   <= d_pc;
            full   <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding imem request, stall buffering and branch redirect.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_valid
);

    if_state_e       state, state_nxt;
    logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
    logic            req_nxt;
    logic [XLEN-1:0] addr_nxt, pc_nxt, inst_nxt;
    logic            valid_nxt;
    logic [XLEN-1:0] target, pc_inc;
    logic            buf_load, buf_clear, buf_full;
    logic [XLEN-1:0] buf_inst, buf_pc;

    assign target = word_align(branch_addr);
    assign pc_inc = fetch_pc + XLEN'(4);

    if_fetch_buf u_buf (
        .clk    (clk),
        .reset  (reset),
        .load   (buf_load),
        .clear  (buf_clear),
        .d_inst (imem_rdata),
        .d_pc   (fetch_pc),
        .q_inst (buf_inst),
        .q_pc   (buf_pc),
        .full   (buf_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            pc         <= '0;
            inst       <= NOP;
            inst_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            fetch_pc   <= fetch_pc_nxt;
            imem_req   <= req_nxt;
            imem_addr  <= addr_nxt;
            pc         <= pc_nxt;
            inst       <= inst_nxt;
            inst_valid <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        req_nxt      = imem_req;
        addr_nxt     = imem_addr;
        pc_nxt       = pc;
        inst_nxt     = inst;
        valid_nxt    = inst_valid;
        buf_load     = 1'b0;
        buf_clear    = 1'b0;

        // A released ID sees a bubble unless a branch below delivers something.
        if (!stall) begin
            valid_nxt = 1'b0;
            inst_nxt  = NOP;
        end

        case (state)
            IDLE: begin
                state_nxt = FETCH;
                req_nxt   = 1'b1;
                if (br && !stall) begin
                    fetch_pc_nxt = target;
                    addr_nxt     = target;
                end else begin
                    addr_nxt     = fetch_pc;
                end
            end

            FETCH: begin
                if (stall) begin
                    if (imem_rvalid) begin
                        buf_load  = 1'b1;
                        state_nxt = HOLD;
                        req_nxt   = 1'b0;
                    end
                end else if (br) begin
                    fetch_pc_nxt = target;
                    buf_clear    = 1'b1;
                    if (imem_rvalid) begin
                        addr_nxt  = target;
                    end else begin
                        state_nxt = SQUASH;
                    end
                end else if (imem_rvalid) begin
                    pc_nxt       = fetch_pc;
                    inst_nxt     = imem_rdata;
                    valid_nxt    = 1'b1;
                    fetch_pc_nxt = pc_inc;
                    addr_nxt     = pc_inc;
                end
            end

            HOLD: begin
                if (!stall) begin
                    state_nxt = FETCH;
                    req_nxt   = 1'b1;
                    buf_clear = 1'b1;
                    if (br) begin
                        fetch_pc_nxt = target;
                        addr_nxt     = target;
                    end else if (buf_full) begin
                        pc_nxt       = buf_pc;
                        inst_nxt     = buf_inst;
                        valid_nxt    = 1'b1;
                        fetch_pc_nxt = pc_inc;
                        addr_nxt     = pc_inc;
                    end else begin
                        addr_nxt     = fetch_pc;
                    end
                end
            end

            SQUASH: begin
                if (br && !stall) begin
                    fetch_pc_nxt = target;
                    buf_clear    = 1'b1;
                end
                // The stale response is dropped; refetch from the redirect target.
                if (imem_rvalid) begin
                    state_nxt = FETCH;
                    addr_nxt  = (br && !stall) ? target : fetch_pc;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a variable-latency instruction memory model.
module tb_if_stage;

    localparam logic [31:0] NOP_W = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, stall, br;
    logic [31:0] branch_addr;
    logic        imem_req, imem_rvalid, inst_valid;
    logic [31:0] imem_addr, imem_rdata, pc, inst;

    logic        w_req, w_rvalid, w_valid;
    logic [31:0] w_addr, w_rdata, w_pc, w_inst;

    int unsigned lat;
    logic        inject;
    int          n_chk = 0;
    int          n_pass = 0;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .br          (br),
        .branch_addr (branch_addr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .inst        (inst),
        .inst_valid  (inst_valid)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk         (clk),
        .reset       (reset),
        .stall       (1'b0),
        .br          (1'b0),
        .branch_addr (32'h0),
        .imem_req    (w_req),
        .imem_addr   (w_addr),
        .imem_rvalid (w_rvalid),
        .imem_rdata  (w_rdata),
        .pc          (w_pc),
        .inst        (w_inst),
        .inst_valid  (w_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0010_0093;
            32'h4:   return 32'h0020_0093;
            32'h8:   return 32'h0050_0093;
            32'hC:   return 32'h00C0_0093;
            default: return 32'hA000_0000 | a;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Memory responder: one request at a time, response after lat cycles.
    initial begin
        logic        busy;
        logic        delivered;
        int unsigned cnt;
        logic [31:0] req_addr;
        busy = 1'b0; cnt = 0; req_addr = '0;
        imem_rvalid = 1'b0; imem_rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            imem_rvalid = 1'b0;
            delivered   = 1'b0;
            if (!reset) begin
                busy        = 1'b0;
                imem_rvalid = inject;
                imem_rdata  = 32'hDEAD_BEEF;
            end else begin
                if (busy) begin
                    if (cnt <= 1) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = mem_word(req_addr);
                        busy        = 1'b0;
                        delivered   = 1'b1;
                    end else begin
                        cnt--;
                    end
                end
                if (!busy && !delivered && imem_req) begin
                    busy     = 1'b1;
                    cnt      = lat;
                    req_addr = imem_addr;
                end
            end
        end
    end

    initial begin
        reset = 1'b0; stall = 1'b0; br = 1'b0; branch_addr = '0;
        lat = 1; inject = 1'b0; w_rvalid = 1'b0; w_rdata = '0;

        step(); step();
        check("rst_req",   32'(imem_req),   32'h0);
        check("rst_addr",  imem_addr,       32'h0);
        check("rst_pc",    pc,              32'h0);
        check("rst_inst",  inst,            NOP_W);
        check("rst_valid", 32'(inst_valid), 32'h0);
        check("rst_waddr", w_addr,          32'hFFFF_FFFC);
        reset = 1'b1;

        // Reset release with single-cycle memory
        step();
        check("rel_req",  32'(imem_req),   32'h1);
        check("rel_addr", imem_addr,       32'h0);
        check("rel_val",  32'(inst_valid), 32'h0);
        step();
        check("f0_wait",  32'(inst_valid), 32'h0);
        step();
        check("f0_pc",    pc,              32'h0);
        check("f0_inst",  inst,            32'h0010_0093);
        check("f0_val",   32'(inst_valid), 32'h1);
        check("f0_addr",  imem_addr,       32'h4);
        step();
        check("f1_bub",   32'(inst_valid), 32'h0);
        check("f1_nop",   inst,            NOP_W);
        step();
        check("f1_pc",    pc,              32'h4);
        check("f1_inst",  inst,            32'h0020_0093);
        check("f1_addr",  imem_addr,       32'h8);

        // Stall with the 0x8 response arriving mid-stall
        stall = 1'b1;
        step();
        check("st_pc0",   pc,              32'h4);
        check("st_val0",  32'(inst_valid), 32'h1);
        step();
        check("st_req",   32'(imem_req),   32'h0);
        check("st_pc1",   pc,              32'h4);
        check("st_inst1", inst,            32'h0020_0093);
        step();
        check("st_req2",  32'(imem_req),   32'h0);
        stall = 1'b0;
        step();
        check("hl_pc",    pc,              32'h8);
        check("hl_inst",  inst,            32'h0050_0093);
        check("hl_val",   32'(inst_valid), 32'h1);
        check("hl_addr",  imem_addr,       32'hC);
        check("hl_req",   32'(imem_req),   32'h1);

        // Branch while the 0xC request is outstanding, 3-cycle memory
        lat = 3;
        step();
        check("sq_bub",   32'(inst_valid), 32'h0);
        br = 1'b1; branch_addr = 32'h40;
        step();
        check("sq_addr0", imem_addr,       32'hC);
        check("sq_req",   32'(imem_req),   32'h1);
        check("sq_val0",  32'(inst_valid), 32'h0);
        br = 1'b0;
        step();
        check("sq_addr1", imem_addr,       32'hC);
        step();
        check("sq_addr2", imem_addr,       32'h40);
        check("sq_inst",  inst,            NOP_W);
        for (int i = 0; i < 3; i++) begin
            step();
            check("sq_noval", 32'(inst_valid), 32'h0);
        end
        step();
        check("br_pc",    pc,              32'h40);
        check("br_inst",  inst,            32'hA000_0040);
        check("br_val",   32'(inst_valid), 32'h1);
        check("br_addr",  imem_addr,       32'h44);

        // Branch coincident with the response, misaligned target
        lat = 1;
        step();
        check("co_bub",   32'(inst_valid), 32'h0);
        br = 1'b1; branch_addr = 32'h103;
        step();
        check("co_addr",  imem_addr,       32'h100);
        check("co_inst",  inst,            NOP_W);
        check("co_val",   32'(inst_valid), 32'h0);
        check("co_req",   32'(imem_req),   32'h1);
        br = 1'b0;
        step();
        step();
        check("co_pc",    pc,              32'h100);
        check("co_inst2", inst,            32'hA000_0100);

        // Reset mid-request with rvalid pulsed during reset
        lat = 3;
        step();
        reset = 1'b0; inject = 1'b1;
        step();
        check("mr_req",   32'(imem_req),   32'h0);
        check("mr_val",   32'(inst_valid), 32'h0);
        check("mr_pc",    pc,              32'h0);
        check("mr_inst",  inst,            NOP_W);
        step();
        reset = 1'b1; inject = 1'b0;
        step();
        check("mr_addr",  imem_addr,       32'h0);
        check("mr_req1",  32'(imem_req),   32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("mr_stale", 32'(inst_valid), 32'h0);
        end
        step();
        check("mr_pc1",   pc,              32'h0);
        check("mr_inst1", inst,            32'h0010_0093);
        check("mr_val1",  32'(inst_valid), 32'h1);

        // Wrap-around on the second instance; stall the main one toward HOLD
        check("wr_addr0", w_addr,          32'hFFFF_FFFC);
        check("wr_req0",  32'(w_req),      32'h1);
        w_rvalid = 1'b1; w_rdata = 32'h0070_0093;
        stall = 1'b1;
        step();
        check("wr_addr1", w_addr,          32'h0);
        check("wr_pc",    w_pc,            32'hFFFF_FFFC);
        check("wr_inst",  w_inst,          32'h0070_0093);
        check("wr_val",   32'(w_valid),    32'h1);
        w_rvalid = 1'b0;
        step(); step();

        // Branch while holding a buffered instruction
        step();
        check("hb_req",   32'(imem_req),   32'h0);
        check("hb_pc",    pc,              32'h0);
        check("hb_val",   32'(inst_valid), 32'h1);
        stall = 1'b0; br = 1'b1; branch_addr = 32'h200; lat = 1;
        step();
        check("hb_addr",  imem_addr,       32'h200);
        check("hb_req1",  32'(imem_req),   32'h1);
        check("hb_val1",  32'(inst_valid), 32'h0);
        check("hb_inst",  inst,            NOP_W);
        br = 1'b0;
        step();
        step();
        check("hb_pc2",   pc,              32'h200);
        check("hb_inst2", inst,            32'hA000_0200);
        check("hb_addr2", imem_addr,       32'h204);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
